// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: computes mult/multu/div/divu results at issue,
// holds them for a fixed busy latency, then commits them to HI/LO.
module md_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_Ex,
   input  logic [2:0]  mdOp_Ex,
   input  logic [31:0] mdA_Ex,
   input  logic [31:0] mdB_Ex,
   output logic        busy_Hz,
   output logic        mdStall_Hz,
   output logic        done_Hz,
   output logic [31:0] hi_Ex,
   output logic [31:0] lo_Ex
);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e      r_state, w_state_d;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_phi, r_plo;
   logic        r_divz, r_done;

   logic        w_is_md, w_issue, w_commit, w_busy;
   logic        w_signed_div;
   logic [63:0] w_prod_u, w_prod_s;
   logic [31:0] w_abs_a, w_abs_b, w_dvd, w_dvs, w_dvs_safe, w_q, w_r;
   logic [31:0] w_res_hi, w_res_lo;

   assign w_is_md  = start_Ex && (mdOp_Ex >= OpMult) && (mdOp_Ex <= OpDivu);
   assign w_issue  = w_is_md && (r_state == StIdle);
   assign w_commit = (r_state == StBusy) && (r_cnt == 4'd0);

   // Full-width products; the signed one uses sign-extended operands.
   assign w_prod_u = {32'b0, mdA_Ex} * {32'b0, mdB_Ex};
   assign w_prod_s = {{32{mdA_Ex[31]}}, mdA_Ex} * {{32{mdB_Ex[31]}}, mdB_Ex};

   // Signed divide works on magnitudes; 0x80000000 stays 0x80000000 when negated,
   // which yields the required 0x80000000 / -1 result without a special case.
   assign w_signed_div = (mdOp_Ex == OpDiv);
   assign w_abs_a      = mdA_Ex[31] ? (~mdA_Ex + 32'd1) : mdA_Ex;
   assign w_abs_b      = mdB_Ex[31] ? (~mdB_Ex + 32'd1) : mdB_Ex;
   assign w_dvd        = w_signed_div ? w_abs_a : mdA_Ex;
   assign w_dvs        = w_signed_div ? w_abs_b : mdB_Ex;
   // Divisor forced to 1 on zero so the divider never produces X; result is discarded.
   assign w_dvs_safe   = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
   assign w_q          = w_dvd / w_dvs_safe;
   assign w_r          = w_dvd % w_dvs_safe;

   // Select the pending result for the issued operation.
   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      unique case (mdOp_Ex)
         OpMult:  {w_res_hi, w_res_lo} = w_prod_s;
         OpMultu: {w_res_hi, w_res_lo} = w_prod_u;
         OpDiv: begin
            w_res_lo = (mdA_Ex[31] ^ mdB_Ex[31]) ? (~w_q + 32'd1) : w_q;
            w_res_hi = mdA_Ex[31] ? (~w_r + 32'd1) : w_r;
         end
         OpDivu: begin
            w_res_lo = w_q;
            w_res_hi = w_r;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= StIdle;
      else        r_state <= w_state_d;
   end

   // Next-state logic: IDLE -> BUSY on mult/div issue, back when the counter expires.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_issue)  w_state_d = StBusy;
         StBusy:  if (w_commit) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers.
   always_comb begin
      w_busy     = (r_state == StBusy);
      busy_Hz    = w_busy;
      mdStall_Hz = w_busy | w_is_md;
      done_Hz    = r_done;
      hi_Ex      = r_hi;
      lo_Ex      = r_lo;
   end

   // Datapath: counter, pending result capture, HI/LO commit and mthi/mtlo writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= 4'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_phi  <= 32'd0;
         r_plo  <= 32'd0;
         r_divz <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == StIdle) begin
            if (w_issue) begin
               r_cnt  <= (mdOp_Ex <= OpMultu) ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
               r_phi  <= w_res_hi;
               r_plo  <= w_res_lo;
               r_divz <= (mdOp_Ex >= OpDiv) && (mdB_Ex == 32'd0);
            end else if (start_Ex && (mdOp_Ex == OpMthi)) begin
               r_hi <= mdA_Ex;
            end else if (start_Ex && (mdOp_Ex == OpMtlo)) begin
               r_lo <= mdA_Ex;
            end
         end else begin
            r_cnt <= r_cnt - 4'd1;
            if (w_commit) begin
               r_cnt  <= 4'd0;
               r_done <= 1'b1;
               if (!r_divz) begin
                  r_hi <= r_phi;
                  r_lo <= r_plo;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a scoreboard of expected HI/LO commits.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_Ex;
   logic [2:0]  mdOp_Ex;
   logic [31:0] mdA_Ex, mdB_Ex;
   logic        busy_Hz, mdStall_Hz, done_Hz;
   logic [31:0] hi_Ex, lo_Ex;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_Ex   (start_Ex),
      .mdOp_Ex    (mdOp_Ex),
      .mdA_Ex     (mdA_Ex),
      .mdB_Ex     (mdB_Ex),
      .busy_Hz    (busy_Hz),
      .mdStall_Hz (mdStall_Hz),
      .done_Hz    (done_Hz),
      .hi_Ex      (hi_Ex),
      .lo_Ex      (lo_Ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one issue cycle, check the combinational stall, then release inputs.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start_Ex = 1'b1;
      mdOp_Ex  = op;
      mdA_Ex   = a;
      mdB_Ex   = b;
      #1;
      chk("stall_issue", {31'b0, mdStall_Hz},
          {31'b0, (busy_Hz === 1'b1) || (op >= 3'd1 && op <= 3'd4)});
      step();
      start_Ex = 1'b0;
      mdOp_Ex  = 3'd0;
      mdA_Ex   = 32'd0;
      mdB_Ex   = 32'd0;
   endtask

   // Count busy cycles (k0 already seen), then compare the commit against the scoreboard.
   task automatic wait_done(input string tag, input int n, input int k0);
      logic [63:0] e;
      int k;
      k = k0;
      while (busy_Hz === 1'b1 && k < 20) begin
         chk({tag, "_done_low"}, {31'b0, done_Hz}, 32'd0);
         chk({tag, "_stall_busy"}, {31'b0, mdStall_Hz}, 32'd1);
         chk({tag, "_hi_hold"}, hi_Ex, m_hi);
         chk({tag, "_lo_hold"}, lo_Ex, m_lo);
         k++;
         step();
      end
      chk({tag, "_busy_cycles"}, k, n);
      chk({tag, "_done_pulse"}, {31'b0, done_Hz}, 32'd1);
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_hi"}, hi_Ex, e[63:32]);
         chk({tag, "_lo"}, lo_Ex, e[31:0]);
         m_hi = e[63:32];
         m_lo = e[31:0];
      end
   endtask

   initial begin
      reset    = 1'b0;
      start_Ex = 1'b0;
      mdOp_Ex  = 3'd0;
      mdA_Ex   = 32'd0;
      mdB_Ex   = 32'd0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
      step();
      step();
      chk("rst_busy", {31'b0, busy_Hz}, 32'd0);
      chk("rst_done", {31'b0, done_Hz}, 32'd0);
      chk("rst_stall", {31'b0, mdStall_Hz}, 32'd0);
      chk("rst_hi", hi_Ex, 32'd0);
      chk("rst_lo", lo_Ex, 32'd0);
      reset = 1'b1;
      step();

      // mult -1 * 2
      sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_done("mult", 5, 0);
      step();
      chk("mult_done_once", {31'b0, done_Hz}, 32'd0);

      // multu 0xFFFFFFFF * 2
      sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu", 5, 0);

      // div -7 / 2, issued in the first non-busy cycle
      sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done("div", 10, 0);

      // mthi then divu by zero: HI/LO unchanged
      issue(3'd5, 32'h0000_1234, 32'd0);
      chk("mthi_busy", {31'b0, busy_Hz}, 32'd0);
      chk("mthi_hi", hi_Ex, 32'h0000_1234);
      chk("mthi_no_done", {31'b0, done_Hz}, 32'd0);
      m_hi = 32'h0000_1234;
      sb_q.push_back({32'h0000_1234, m_lo});
      issue(3'd4, 32'd5, 32'd0);
      wait_done("divz", 10, 0);

      // divu 100 / 7 back-to-back
      sb_q.push_back({32'd2, 32'd14});
      issue(3'd4, 32'd100, 32'd7);
      wait_done("divu", 10, 0);

      // reserved op ignored
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      chk("rsv_busy", {31'b0, busy_Hz}, 32'd0);
      chk("rsv_hi", hi_Ex, m_hi);
      chk("rsv_lo", lo_Ex, m_lo);

      // mult 3*4 with mtlo attempted while busy
      sb_q.push_back({32'd0, 32'd12});
      issue(3'd1, 32'd3, 32'd4);
      chk("ibusy_c1_stall", {31'b0, mdStall_Hz}, 32'd1);
      chk("ibusy_c1_busy", {31'b0, busy_Hz}, 32'd1);
      step();
      issue(3'd6, 32'h0000_00AA, 32'd0);
      chk("ibusy_c3_lo", lo_Ex, m_lo);
      wait_done("ibusy", 5, 2);

      // div 0x80000000 / -1 overflow case
      sb_q.push_back({32'd0, 32'h8000_0000});
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("divovf", 10, 0);

      // reset mid-operation discards the pending result
      issue(3'd5, 32'h5555_5555, 32'd0);
      chk("mthi2_hi", hi_Ex, 32'h5555_5555);
      issue(3'd3, 32'd100, 32'd3);
      step();
      step();
      step();
      chk("rmid_busy_before", {31'b0, busy_Hz}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rmid_busy", {31'b0, busy_Hz}, 32'd0);
      chk("rmid_hi", hi_Ex, 32'd0);
      chk("rmid_lo", lo_Ex, 32'd0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("rpost_busy", {31'b0, busy_Hz}, 32'd0);
         chk("rpost_done", {31'b0, done_Hz}, 32'd0);
         chk("rpost_hi", hi_Ex, 32'd0);
         chk("rpost_lo", lo_Ex, 32'd0);
      end
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the EX stage of the five-stage pipeline. It accepts one mult/multu/div/divu/mthi/mtlo operation per issue and computes the product or quotient/remainder over a fixed multi-cycle latency. It then commits the result to its internal HI/LO registers. Busy and stall status go to the hazard unit, which holds any HI/LO-touching instruction in ID until the sequencer is free.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy duration for mult/multu, range 2..15.
- DIV_CYCLES, default 10: busy duration for div/divu, range 2..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low; 0 clears all state immediately.
- start_Ex, input, 1: an operation is issued this cycle; sampled on the rising edge.
- mdOp_Ex, input, 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- mdA_Ex, input, 32: rs operand, already forwarded.
- mdB_Ex, input, 32: rt operand, already forwarded.
- busy_Hz, output, 1: a mult/div is in flight.
- mdStall_Hz, output, 1: combinational; busy_Hz | (start_Ex & mdOp_Ex in 1..4).
- done_Hz, output, 1: one-cycle pulse in the first cycle after a commit.
- hi_Ex, output, 32: current HI register.
- lo_Ex, output, 32: current LO register.

## Operation
- Two states: IDLE and BUSY. Also keeps a 4-bit down-counter cnt and 32-bit pending registers pHi/pLo.
- Transition IDLE -> BUSY: on an edge with start_Ex=1 and mdOp_Ex in 1..4.
  - cnt loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - pHi/pLo are computed from mdA_Ex/mdB_Ex at that edge and stored.
- Result rules:
  - mult: {pHi,pLo} = signed 64-bit product.
  - multu: {pHi,pLo} = unsigned 64-bit product.
  - div: pLo = signed quotient, truncated toward zero. pHi = remainder, with the sign of the dividend.
  - div, 0x80000000 / 0xFFFFFFFF: pLo=0x80000000, pHi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): the op runs its full latency, then commits nothing; HI/LO are unchanged.
- BUSY: cnt decrements by 1 each edge. On the edge where cnt==0:
  - HI<=pHi and LO<=pLo (unless divide by zero).
  - State returns to IDLE.
  - done_Hz is set for the next cycle.
- mthi/mtlo: in IDLE with start_Ex=1, HI (or LO) <= mdA_Ex on that edge. No busy, no done.
- start_Ex while BUSY: ignored, with no state change. The hazard unit guarantees this never happens; the verifier asserts on it.
- mdOp_Ex 0 or 7 with start_Ex=1: ignored.
- reset=0 at any time, including mid-operation:
  - State=IDLE, cnt=0, HI=LO=pHi=pLo=0, busy_Hz=0, done_Hz=0.
  - Any pending result is discarded.

## Timing
- Reset values: busy_Hz=0, done_Hz=0, hi_Ex=0, lo_Ex=0. mdStall_Hz follows its combinational equation.
- Latency: issue edge E0. busy_Hz is high from just after E0 until just after E0+N, for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- At edge E0+N: hi_Ex/lo_Ex take the new value; busy_Hz=0 and done_Hz=1 in the following cycle.
- A new mult/div may issue at edge E0+N+... : the earliest is the cycle in which busy_Hz first reads 0, i.e. the edge after E0+N. Back-to-back throughput is N+1 cycles per op, not N.
- mthi/mtlo: the value is visible on hi_Ex/lo_Ex in the cycle after the issue edge.
- mdStall_Hz is high in the issue cycle itself (combinational on start_Ex). This lets the hazard unit stall a dependent mfhi/mflo in ID with no gap.
- Outputs hi_Ex/lo_Ex never change while busy_Hz=1.

## Test plan
- Reset, then mult with A=0xFFFFFFFF (-1), B=2 -> busy_Hz high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, and done_Hz pulses once.
- multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide by zero: mthi with 0x1234, then divu with A=5, B=0 -> busy_Hz for 10 cycles, done_Hz pulses, HI stays 0x1234.
- Reset mid-op: issue div, drive reset=0 at cycle 4 -> busy_Hz, hi_Ex and lo_Ex read 0 immediately; no later commit occurs after reset is released.
- Issue while busy: mult 3*4, then start_Ex with mtlo 0xAA at cycle 2 -> mtlo is ignored and LO=12 at commit. Also check mdStall_Hz=1 in the issue cycle and for all 5 busy cycles.
